// File: rtl/draw_grid_cells_if.sv
// VGA pixel-stream bundle: 11-bit counters, sync/blank strobes and 12-bit rgb.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_grid_cells.sv
// N x N board overlay with per-cell state memory, cursor highlight and bulk clear.
// Latency 2 cycles on the pixel stream; writes back-pressured (wr_ready=0) while clearing.
module draw_grid_cells #(
  parameter int          X_POS        = 0,
  parameter int          Y_POS        = 0,
  parameter int          CELLS        = 12,
  parameter int          CELL_LOG2    = 5,
  parameter int          BORDER       = 2,
  parameter logic [11:0] COLOR_LINE   = 12'h000,
  parameter logic [11:0] COLOR_SHIP   = 12'h888,
  parameter logic [11:0] COLOR_MISS   = 12'h00F,
  parameter logic [11:0] COLOR_HIT    = 12'hF00,
  parameter logic [11:0] COLOR_CURSOR = 12'hFF0
) (
  input  logic       clk,
  input  logic       rst,
  vga_if.in          in,
  vga_if.out         out,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic [1:0] wr_state,
  input  logic       clr_req,
  output logic       busy,
  input  logic       cur_en,
  input  logic [3:0] cur_x,
  input  logic [3:0] cur_y
);

  localparam int          NCELL = CELLS * CELLS;
  localparam logic [11:0] X_BEG = 12'(X_POS);
  localparam logic [11:0] Y_BEG = 12'(Y_POS);
  localparam logic [11:0] X_END = 12'(X_POS + (CELLS << CELL_LOG2) + BORDER);
  localparam logic [11:0] Y_END = 12'(Y_POS + (CELLS << CELL_LOG2) + BORDER);
  localparam logic [4:0]  CELLS5 = 5'(CELLS);
  localparam logic [CELL_LOG2-1:0] BORD = CELL_LOG2'(BORDER);
  localparam logic [7:0]  LAST_IDX = 8'(NCELL - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state;
  logic [7:0] clr_cnt;
  logic [1:0] cells [NCELL];

  // Stage 1: geometry
  logic [10:0] rel_x, rel_y, sh_x, sh_y;
  logic [4:0]  col_c, row_c;
  logic        in_grid_c, on_line_c;

  assign rel_x = in.hcount - 11'(X_POS);
  assign rel_y = in.vcount - 11'(Y_POS);
  assign sh_x  = rel_x >> CELL_LOG2;
  assign sh_y  = rel_y >> CELL_LOG2;
  assign col_c = sh_x[4:0];
  assign row_c = sh_y[4:0];

  // Compare on the absolute counter so pixels before the grid never wrap into it.
  assign in_grid_c = ({1'b0, in.hcount} >= X_BEG) && ({1'b0, in.hcount} < X_END) &&
                     ({1'b0, in.vcount} >= Y_BEG) && ({1'b0, in.vcount} < Y_END);
  assign on_line_c = (rel_x[CELL_LOG2-1:0] < BORD) || (rel_y[CELL_LOG2-1:0] < BORD) ||
                     (col_c == CELLS5) || (row_c == CELLS5);

  logic [10:0] s1_vcount, s1_hcount;
  logic        s1_vsync, s1_vblnk, s1_hsync, s1_hblnk;
  logic [11:0] s1_rgb;
  logic        s1_in_grid, s1_on_line;
  logic [4:0]  s1_col, s1_row;
  logic        s1_cur_en;
  logic [3:0]  s1_cur_x, s1_cur_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vcount  <= '0;
      s1_vsync   <= 1'b0;
      s1_vblnk   <= 1'b0;
      s1_hcount  <= '0;
      s1_hsync   <= 1'b0;
      s1_hblnk   <= 1'b0;
      s1_rgb     <= '0;
      s1_in_grid <= 1'b0;
      s1_on_line <= 1'b0;
      s1_col     <= '0;
      s1_row     <= '0;
      s1_cur_en  <= 1'b0;
      s1_cur_x   <= '0;
      s1_cur_y   <= '0;
    end else begin
      s1_vcount  <= in.vcount;
      s1_vsync   <= in.vsync;
      s1_vblnk   <= in.vblnk;
      s1_hcount  <= in.hcount;
      s1_hsync   <= in.hsync;
      s1_hblnk   <= in.hblnk;
      s1_rgb     <= in.rgb;
      s1_in_grid <= in_grid_c;
      s1_on_line <= on_line_c;
      s1_col     <= col_c;
      s1_row     <= row_c;
      s1_cur_en  <= cur_en;
      s1_cur_x   <= cur_x;
      s1_cur_y   <= cur_y;
    end
  end

  // Stage 2: state lookup and colour select
  logic [7:0]  rd_idx;
  logic [1:0]  cell_st;
  logic        cur_hit;
  logic [11:0] rgb_c;

  assign rd_idx  = 8'(int'(s1_row) * CELLS + int'(s1_col));
  assign cur_hit = s1_cur_en && ({1'b0, s1_cur_x} < CELLS5) && ({1'b0, s1_cur_y} < CELLS5) &&
                   ({1'b0, s1_cur_x} == s1_col) && ({1'b0, s1_cur_y} == s1_row);

  always_comb begin
    cell_st = 2'd0;
    if ((s1_col < CELLS5) && (s1_row < CELLS5))
      cell_st = cells[rd_idx];
  end

  always_comb begin
    rgb_c = s1_rgb;
    if (s1_vblnk || s1_hblnk)  rgb_c = 12'h000;
    else if (!s1_in_grid)      rgb_c = s1_rgb;
    else if (s1_on_line)       rgb_c = COLOR_LINE;
    else if (cur_hit)          rgb_c = COLOR_CURSOR;
    else begin
      case (cell_st)
        2'd3:    rgb_c = COLOR_HIT;
        2'd2:    rgb_c = COLOR_MISS;
        2'd1:    rgb_c = COLOR_SHIP;
        default: rgb_c = s1_rgb;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out.vcount <= '0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hcount <= '0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.vcount <= s1_vcount;
      out.vsync  <= s1_vsync;
      out.vblnk  <= s1_vblnk;
      out.hcount <= s1_hcount;
      out.hsync  <= s1_hsync;
      out.hblnk  <= s1_hblnk;
      out.rgb    <= rgb_c;
    end
  end

  // Cell memory and write/clear sequencer
  logic [7:0] wr_idx;
  logic       wr_in_range;

  assign wr_idx      = 8'(int'(wr_y) * CELLS + int'(wr_x));
  assign wr_in_range = ({1'b0, wr_x} < CELLS5) && ({1'b0, wr_y} < CELLS5);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wr_ready <= 1'b0;
      busy     <= 1'b0;
      clr_cnt  <= '0;
      for (int i = 0; i < NCELL; i++) cells[i] <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          wr_ready <= 1'b1;
          busy     <= 1'b0;
          if (wr_valid && wr_ready && wr_in_range)
            cells[wr_idx] <= wr_state;
          if (clr_req) begin
            state    <= CLEAR;
            wr_ready <= 1'b0;
            busy     <= 1'b1;
            clr_cnt  <= '0;
          end
        end
        CLEAR: begin
          cells[clr_cnt] <= 2'd0;
          if (clr_cnt == LAST_IDX) begin
            state    <= IDLE;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
            clr_cnt  <= '0;
          end else begin
            clr_cnt <= clr_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
